// File: rtl/ntt_dout_collector.sv
// rtl/ntt_dout_collector.sv - collects the NTT output stream into a buffer and replays it in natural order
//
// Purpose: after arm, waits for done, drops one skip cycle, then captures
// data words from dout0. A zero word on dout0 ends one group. Each captured
// word is reduced by one conditional subtraction of Q. It is then stored
// de-interleaved: even words go to the lower half and odd words to the upper
// half. When the last group ends, the buffer is read out as a ready/valid
// stream of (rd_index, rd_data) pairs.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   arm        in   one-cycle start pulse, sampled only in IDLE
//   ring_size  in   polynomial length (power of two, 64..MAXN)
//   done       in   NTT core done flag
//   dout0      in   NTT output word; zero = group delimiter
//   busy       out  registered, high outside IDLE
//   rd_valid   out  readout word valid
//   rd_ready   in   readout word accepted
//   rd_data    out  reduced coefficient
//   rd_index   out  coefficient index of rd_data
//   complete   out  one-cycle pulse after the last readout word is accepted
//   err        out  sticky collection error, cleared by arm

module ntt_dout_collector #(
  parameter int DW       = 32,
  parameter int Q        = 12289,
  parameter int MAXN     = 512,
  parameter int PE_DEPTH = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic [11:0]   ring_size,
  input  logic          done,
  input  logic [DW-1:0] dout0,
  output logic          busy,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [9:0]    rd_index,
  output logic          complete,
  output logic          err
);

  localparam int            AW  = $clog2(MAXN);
  localparam logic [DW-1:0] Q_W = DW'(Q);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_SKIP,
    S_CAPTURE,
    S_READOUT
  } state_t;

  state_t        state;
  logic [11:0]   n_reg;
  logic [11:0]   m_cnt;
  logic [11:0]   g_cnt;
  logic [11:0]   fetch_idx;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] mem [MAXN];

  logic [11:0]   g_target;
  logic [11:0]   g_next;
  logic [11:0]   half_n;
  logic [11:0]   wr_addr_full;
  logic [DW-1:0] dout_red;
  logic          rd_fire;
  logic          last_fire;
  logic          rd_load;
  logic          unused_addr_bits;

  assign g_target = n_reg >> (PE_DEPTH + 1);
  assign g_next   = g_cnt + 12'd1;
  assign half_n   = n_reg >> 1;

  // Even words go to the lower half and odd words to the upper half, so the
  // buffer ends up in natural coefficient order.
  assign wr_addr_full = m_cnt[0] ? ((m_cnt >> 1) + half_n) : (m_cnt >> 1);
  assign unused_addr_bits = ^wr_addr_full[11:AW];

  // Inputs are at most one modulus above the range, so a single subtraction
  // is enough.
  assign dout_red = (dout0 >= Q_W) ? (dout0 - Q_W) : dout0;

  assign rd_fire   = rd_valid & rd_ready;
  assign last_fire = rd_fire && ({2'b00, rd_index} == (n_reg - 12'd1));
  // The output register is refilled when it is empty or when its word is
  // being taken. This keeps one word per cycle under rd_ready=1, and holds
  // the word while the consumer stalls.
  assign rd_load   = (!rd_valid || rd_ready) && (fetch_idx < n_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      rd_valid  <= 1'b0;
      complete  <= 1'b0;
      err       <= 1'b0;
      n_reg     <= '0;
      m_cnt     <= '0;
      g_cnt     <= '0;
      fetch_idx <= '0;
      rd_data   <= '0;
      rd_index  <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      complete <= 1'b0;
      wr_en    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arm) begin
            n_reg     <= ring_size;
            m_cnt     <= '0;
            g_cnt     <= '0;
            fetch_idx <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
            state     <= S_ARMED;
          end
        end
        S_ARMED: begin
          // The done level is enough; an edge is not required.
          if (done) state <= S_SKIP;
        end
        S_SKIP: begin
          if (g_target == 12'd0) begin
            err   <= 1'b1;
            state <= S_READOUT;
          end else begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (dout0 != '0) begin
            if (m_cnt == n_reg) begin
              err <= 1'b1;
            end else begin
              wr_en   <= 1'b1;
              wr_addr <= wr_addr_full[AW-1:0];
              wr_data <= dout_red;
              m_cnt   <= m_cnt + 12'd1;
            end
          end else begin
            g_cnt <= g_next;
            if (g_next == g_target) begin
              // The last data write lands on this same edge, so the first
              // read on the next edge already sees it.
              if (m_cnt != n_reg) err <= 1'b1;
              state <= S_READOUT;
            end
          end
        end
        S_READOUT: begin
          if (last_fire) begin
            complete <= 1'b1;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else if (rd_load) begin
            rd_data   <= mem[fetch_idx[AW-1:0]];
            rd_index  <= fetch_idx[9:0];
            rd_valid  <= 1'b1;
            fetch_idx <= fetch_idx + 12'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Buffer storage has no reset; the write is one cycle behind the capture.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule
